// File: rtl/manchester_subcarrier_encode.sv
// Load-modulation encoder: frames a bit stream as SOF, Manchester data bits on a
// subcarrier, and a silent EOF period. All outputs except in_req are flops.
module manchester_subcarrier_encode #(
   parameter int unsigned BIT_CYCLES      = 128,
   parameter int unsigned SUBCARRIER_HALF = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic in_data,
   input  logic in_data_valid,
   input  logic in_last_bit,
   output logic in_req,
   output logic lm_out,
   output logic encoding
);

   localparam int unsigned PW     = $clog2(BIT_CYCLES);
   localparam int unsigned SC_BIT = $clog2(SUBCARRIER_HALF);
   localparam logic [PW-1:0] P_LAST = PW'(BIT_CYCLES - 1);
   localparam logic [PW-1:0] P_HALF = PW'(BIT_CYCLES / 2);

   typedef enum logic [1:0] {StIdle, StSof, StData, StEof} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   p_q, p_d;
   logic            bit_q, bit_d;
   logic            last_q, last_d;
   logic            lm_q, lm_d;
   logic            enc_q, enc_d;
   logic            mod_d;
   logic            period_end;

   always_comb begin
      state_d    = state_q;
      p_d        = p_q;
      bit_d      = bit_q;
      last_d     = last_q;
      in_req     = 1'b0;
      period_end = (p_q == P_LAST);
      unique case (state_q)
         StIdle: begin
            if (in_data_valid) begin
               state_d = StSof;
               p_d     = '0;
            end
         end
         StSof, StData: begin
            p_d = p_q + PW'(1);
            if (period_end) begin
               if (state_q == StData && last_q) begin
                  state_d = StEof;
               end else begin
                  // Sample edge: an underrun still acknowledges, then closes the frame.
                  in_req = 1'b1;
                  if (in_data_valid) begin
                     state_d = StData;
                     bit_d   = in_data;
                     last_d  = in_last_bit;
                  end else begin
                     state_d = StEof;
                  end
               end
            end
         end
         StEof: begin
            p_d = p_q + PW'(1);
            if (period_end) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Output flops are computed from next state so modulation lines up with p_q.
   always_comb begin
      mod_d = 1'b0;
      unique case (state_d)
         StSof:   mod_d = (p_d < P_HALF);
         StData:  mod_d = bit_d ? (p_d < P_HALF) : (p_d >= P_HALF);
         default: mod_d = 1'b0;
      endcase
      lm_d  = mod_d & ~p_d[SC_BIT];
      enc_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         p_q     <= '0;
         bit_q   <= 1'b0;
         last_q  <= 1'b0;
         lm_q    <= 1'b0;
         enc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         bit_q   <= bit_d;
         last_q  <= last_d;
         lm_q    <= lm_d;
         enc_q   <= enc_d;
      end
   end

   assign lm_out   = lm_q;
   assign encoding = enc_q;

endmodule

// File: tb/tb_manchester_subcarrier_encode.sv
// Bench for manchester_subcarrier_encode: directed and random frames compared cycle by
// cycle against a period/half-bit model, plus reset aborts.
module tb_manchester_subcarrier_encode;

   localparam int BC = 128;
   localparam int SH = 8;

   logic clk = 1'b0;
   logic rst, in_data, in_data_valid, in_last_bit;
   logic in_req, lm_out, encoding;

   int total = 0;
   int bad   = 0;

   logic fr_bits [0:15];
   int   fr_n, fr_avail;
   logic fr_keep, fr_noise;

   manchester_subcarrier_encode #(
      .BIT_CYCLES     (BC),
      .SUBCARRIER_HALF(SH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_data_valid(in_data_valid),
      .in_last_bit  (in_last_bit),
      .in_req       (in_req),
      .lm_out       (lm_out),
      .encoding     (encoding)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Period 0 is SOF (a 1), periods 1..m carry the consumed bits, then EOF is silent.
   function automatic logic exp_lm(int k, int m);
      int   per, p;
      logic v, modh;
      per = k / BC;
      p   = k % BC;
      if (per == 0) v = 1'b1;
      else if (per <= m) v = fr_bits[per-1];
      else return 1'b0;
      modh = v ? (p < BC / 2) : (p >= BC / 2);
      return modh && ((p / SH) % 2 == 0);
   endfunction

   function automatic logic exp_req(int k, int m);
      int per;
      per = k / BC;
      if (k % BC != BC - 1) return 1'b0;
      if (per == 0) return 1'b1;
      if (per <= m) return (per - 1) != (fr_n - 1);
      return 1'b0;
   endfunction

   // Entered just after a negedge; leaves just after the negedge of the first IDLE cycle.
   task automatic run_frame(input string name);
      int   m, len, idx, reqs, want_reqs;
      logic r;
      m = (fr_avail < fr_n) ? fr_avail : fr_n;
      len = (m + 2) * BC;
      idx = 0;
      reqs = 0;
      want_reqs = 0;
      in_data_valid = 1'b1;
      in_data       = fr_bits[0];
      in_last_bit   = (fr_n == 1);
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         r = exp_req(k, m);
         check($sformatf("%s cyc%0d", name, k), {29'd0, lm_out, encoding, in_req},
               {29'd0, exp_lm(k, m), 1'b1, r});
         if (in_req) reqs++;
         if (r) begin
            want_reqs++;
            in_data_valid = (idx < m);
            in_data       = (idx < m) ? fr_bits[idx] : 1'b0;
            in_last_bit   = (idx < m) && (idx == fr_n - 1);
            idx++;
         end else begin
            in_data_valid = fr_keep ? 1'b1 : (fr_noise ? 1'($urandom) : 1'b0);
            in_data       = fr_noise ? 1'($urandom) : 1'b0;
            in_last_bit   = fr_noise ? 1'($urandom) : 1'b0;
         end
      end
      @(negedge clk);
      check($sformatf("%s idle_gap", name), {29'd0, lm_out, encoding, in_req}, 32'd0);
      check($sformatf("%s req_count", name), reqs, want_reqs);
      in_data_valid = fr_keep;
      in_data       = 1'b0;
      in_last_bit   = 1'b0;
   endtask

   task automatic abort_at(input int c, input string name);
      in_data_valid = 1'b1;
      in_data       = 1'b1;
      in_last_bit   = 1'b1;
      repeat (c + 1) @(negedge clk);
      check({name, " pre"}, {31'd0, encoding}, 32'd1);
      rst = 1'b1;
      in_data_valid = 1'b0;
      @(negedge clk);
      check({name, " abort"}, {29'd0, lm_out, encoding, in_req}, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check({name, " idle"}, {29'd0, lm_out, encoding, in_req}, 32'd0);
      in_data_valid = 1'b1;
      @(negedge clk);
      check({name, " restart"}, {30'd0, lm_out, encoding}, 32'd3);
      rst = 1'b1;
      in_data_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [8:0] a5;
      rst = 1'b1;
      in_data = 1'b0;
      in_data_valid = 1'b0;
      in_last_bit = 1'b0;
      fr_keep = 1'b0;
      fr_noise = 1'b0;
      repeat (3) @(negedge clk);
      check("reset", {29'd0, lm_out, encoding, in_req}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset idle", {29'd0, lm_out, encoding, in_req}, 32'd0);

      // Single last bit: SOF, one 1, EOF.
      fr_bits[0] = 1'b1;
      fr_n = 1;
      fr_avail = 1;
      run_frame("single");
      repeat (3) @(negedge clk);

      // 0xA5 LSB first plus parity 1.
      a5 = 9'h1A5;
      for (int i = 0; i < 9; i++) fr_bits[i] = a5[i];
      fr_n = 9;
      fr_avail = 9;
      run_frame("a5");
      repeat (2) @(negedge clk);

      // Underrun before third sample edge, with in_data noise between samples.
      for (int i = 0; i < 5; i++) fr_bits[i] = 1'($urandom);
      fr_n = 5;
      fr_avail = 2;
      fr_noise = 1'b1;
      run_frame("underrun");
      repeat (2) @(negedge clk);

      // Back-to-back frames with valid held high.
      fr_bits[0] = 1'b0;
      fr_bits[1] = 1'b1;
      fr_n = 2;
      fr_avail = 2;
      fr_keep = 1'b1;
      run_frame("b2b_a");
      fr_bits[0] = 1'b1;
      fr_bits[1] = 1'b0;
      fr_bits[2] = 1'b0;
      fr_n = 3;
      fr_avail = 3;
      fr_keep = 1'b0;
      run_frame("b2b_b");
      repeat (2) @(negedge clk);

      for (int f = 0; f < 6; f++) begin
         fr_n = int'($urandom_range(1, 8));
         for (int i = 0; i < fr_n; i++) fr_bits[i] = 1'($urandom);
         fr_avail = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, fr_n)) : fr_n;
         run_frame($sformatf("rand%0d", f));
         repeat (int'($urandom_range(1, 4))) @(negedge clk);
      end

      fr_noise = 1'b0;
      abort_at(3, "rst_sof");
      abort_at(130, "rst_data");
      abort_at(300, "rst_eof");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
